m_stage_mem: RTL and testbench

Parametrised memory-access stage of the five-stage MIPS pipeline, sitting between the E/M and M/W pipeline registers. It generates sub-word stores with byte enables, sign/zero-extends sub-word loads, and muxes in forwarded store data. It talks to an external data memory through a variable-latency request/ready handshake, stalling the pipeline while waiting. It flags misaligned and timed-out accesses as exceptions, and drives the M/W pipeline register.

---
 rtl/m_stage_mem.sv | 263 ++++++++++++++++++++++++++
 tb/tb_m_stage_mem.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_stage_mem.sv
// m_stage_mem: memory-access stage of the five-stage MIPS pipeline.
//
// Sits between the E/M and M/W pipeline registers. It builds sub-word stores
// (byte enables plus lane-replicated data) and aligns and extends sub-word
// loads. It talks to data memory through a variable-latency req/ready
// handshake and stalls the pipeline while it waits. Misaligned accesses and
// timed-out accesses are reported as exceptions in the M/W register.
//
// Handshake: bus_req is asserted while a request is outstanding. A request
// completes in the cycle where bus_req=1 and bus_ready=1, and bus_rdata is
// sampled only in that cycle. bus_ready without bus_req is ignored. Once a
// request has waited one cycle, addr/be/wdata/we are held stable until it
// completes, is drained or times out.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   m_valid, m_flush          M-stage instruction valid / kill
//   m_ld, m_st, m_size,       load/store, size (0 byte, 1 half, 2/3 word),
//   m_sext                    sign-extend for sub-word loads
//   m_ao, m_rt                effective address, E/M store data
//   fwd_sel, fwd_data         W-stage forward of the store data
//   m_ir, m_pc4               instruction word, PC+4
//   bus_*                     data-memory request/response
//   stall_o                   freeze PC, F/D, D/E and E/M
//   w_*                       M/W pipeline register
//   dbg_state                 current FSM state (0 idle, 1 wait, 2 drain)
module m_stage_mem #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  logic              m_flush,
  input  logic              m_ld,
  input  logic              m_st,
  input  logic [1:0]        m_size,
  input  logic              m_sext,
  input  logic [DATA_W-1:0] m_ao,
  input  logic [DATA_W-1:0] m_rt,
  input  logic              fwd_sel,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic [DATA_W-1:0] m_ir,
  input  logic [DATA_W-1:0] m_pc4,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic              stall_o,
  output logic              w_valid,
  output logic              w_exc,
  output logic [4:0]        w_exc_code,
  output logic [DATA_W-1:0] w_dr,
  output logic [DATA_W-1:0] w_ao,
  output logic [DATA_W-1:0] w_ir,
  output logic [DATA_W-1:0] w_pc4,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_we_q, req_we_d;
  logic [DATA_W-1:0]   req_addr_q, req_addr_d;
  logic [3:0]          req_be_q, req_be_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic                w_valid_d, w_exc_d;
  logic [4:0]          w_exc_code_d;
  logic [DATA_W-1:0]   w_dr_d, w_ao_d, w_ir_d, w_pc4_d;

  logic              memop, misaligned, is_word, is_half;
  logic [DATA_W-1:0] st_data, wdata_c, lane, ld_data;
  logic [3:0]        be_c;
  logic              timeout_hit, complete, bubble, to_exc, latch_en;

  assign memop      = m_valid & (m_ld | m_st) & ~m_flush;
  assign is_word    = m_size[1];            // size 3 behaves as a word
  assign is_half    = (m_size == 2'd1);
  assign misaligned = (is_half & m_ao[0]) | (is_word & (m_ao[1:0] != 2'b00));
  assign st_data    = fwd_sel ? fwd_data : m_rt;

  // Byte enables and lane-replicated store data; loads drive the same enables.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = st_data;
    if (is_half) begin
      be_c    = m_ao[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{st_data[15:0]}};
    end else if (!is_word) begin
      be_c    = 4'b0001 << m_ao[1:0];
      wdata_c = {4{st_data[7:0]}};
    end
  end

  // Move the addressed lane down to the LSBs, then extend.
  assign lane = bus_rdata >> {m_ao[1:0], 3'b000};
  always_comb begin
    if (is_word)      ld_data = bus_rdata;
    else if (is_half) ld_data = {{16{m_sext & lane[15]}}, lane[15:0]};
    else              ld_data = {{24{m_sext & lane[7]}}, lane[7:0]};
  end

  // A flush in WAIT takes the drain path, so it never counts as a timeout.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == S_WAIT) && (cnt_q == TO_CNT)
                       && !bus_ready && !m_flush;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bus_req  = 1'b0;
    stall_o  = 1'b0;
    complete = 1'b0;
    bubble   = 1'b0;
    to_exc   = 1'b0;
    latch_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memop && !misaligned) begin
          bus_req = 1'b1;
          if (bus_ready) begin
            complete = 1'b1;
          end else begin
            stall_o  = 1'b1;
            latch_en = 1'b1;
            state_d  = S_WAIT;
            cnt_d    = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        bus_req = 1'b1;
        if (bus_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (m_flush) bubble = 1'b1;     // data arrives but is discarded
          else         complete = 1'b1;
        end else if (m_flush) begin
          stall_o = 1'b1;
          state_d = S_DRAIN;
        end else if (timeout_hit) begin
          to_exc  = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        bus_req = 1'b1;
        bubble  = 1'b1;
        if (bus_ready) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request fields are captured when the access starts waiting. While stalled,
  // W carries bubbles, so a W-stage forward would not survive the wait.
  always_comb begin
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_be_d    = req_be_q;
    req_wdata_d = req_wdata_q;
    if (latch_en) begin
      req_we_d    = m_st;
      req_addr_d  = {m_ao[DATA_W-1:2], 2'b00};
      req_be_d    = be_c;
      req_wdata_d = wdata_c;
    end
  end

  assign bus_addr  = (state_q == S_IDLE) ? {m_ao[DATA_W-1:2], 2'b00} : req_addr_q;
  assign bus_be    = (state_q == S_IDLE) ? be_c : req_be_q;
  assign bus_wdata = (state_q == S_IDLE) ? wdata_c : req_wdata_q;
  assign bus_we    = bus_req & ((state_q == S_IDLE) ? m_st : req_we_q);
  assign dbg_state = state_q;

  // M/W register: bubble while stalled or draining, otherwise load.
  always_comb begin
    w_valid_d    = w_valid;
    w_exc_d      = w_exc;
    w_exc_code_d = w_exc_code;
    w_dr_d       = w_dr;
    w_ao_d       = w_ao;
    w_ir_d       = w_ir;
    w_pc4_d      = w_pc4;
    if (stall_o || bubble) begin
      w_valid_d = 1'b0;
      w_exc_d   = 1'b0;
      w_ir_d    = '0;
    end else begin
      w_valid_d    = m_valid & ~m_flush;
      w_exc_d      = 1'b0;
      w_exc_code_d = 5'd0;
      w_dr_d       = '0;
      w_ao_d       = m_ao;
      w_ir_d       = m_ir;
      w_pc4_d      = m_pc4;
      if (to_exc) begin
        w_exc_d      = 1'b1;
        w_exc_code_d = 5'd7;
      end else if (memop && misaligned) begin
        w_exc_d      = 1'b1;
        w_exc_code_d = m_ld ? 5'd4 : 5'd5;
      end else if (complete && m_ld) begin
        w_dr_d = ld_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_be_q    <= '0;
      req_wdata_q <= '0;
      w_valid     <= 1'b0;
      w_exc       <= 1'b0;
      w_exc_code  <= '0;
      w_dr        <= '0;
      w_ao        <= '0;
      w_ir        <= '0;
      w_pc4       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_be_q    <= req_be_d;
      req_wdata_q <= req_wdata_d;
      w_valid     <= w_valid_d;
      w_exc       <= w_exc_d;
      w_exc_code  <= w_exc_code_d;
      w_dr        <= w_dr_d;
      w_ao        <= w_ao_d;
      w_ir        <= w_ir_d;
      w_pc4       <= w_pc4_d;
    end
  end

endmodule

// File: tb/tb_m_stage_mem.sv
// Bench for m_stage_mem: directed scenarios plus randomized instructions,
// each checked against a byte-lane reference model of the stage.
module tb_m_stage_mem;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, m_flush, m_ld, m_st, m_sext, fwd_sel;
  logic [1:0]  m_size;
  logic [31:0] m_ao, m_rt, fwd_data, m_ir, m_pc4;
  logic        bus_req, bus_we, bus_ready, stall_o;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        w_valid, w_exc;
  logic [4:0]  w_exc_code;
  logic [31:0] w_dr, w_ao, w_ir, w_pc4;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  m_stage_mem #(.DATA_W(32), .TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .m_valid(m_valid), .m_flush(m_flush), .m_ld(m_ld), .m_st(m_st),
    .m_size(m_size), .m_sext(m_sext), .m_ao(m_ao), .m_rt(m_rt),
    .fwd_sel(fwd_sel), .fwd_data(fwd_data), .m_ir(m_ir), .m_pc4(m_pc4),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .stall_o(stall_o), .w_valid(w_valid), .w_exc(w_exc), .w_exc_code(w_exc_code),
    .w_dr(w_dr), .w_ao(w_ao), .w_ir(w_ir), .w_pc4(w_pc4), .dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] ao);
    int nb, off;
    nb  = nbytes(sz);
    off = int'(ao[1:0]);
    return 4'(((1 << nb) - 1) << off);
  endfunction

  // Lane i of the bus carries data byte (i mod access size).
  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    int nb;
    nb = nbytes(sz);
    r  = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx,
                                           input logic [31:0] ao, input logic [31:0] rd);
    logic [31:0] v, mask;
    int nb;
    nb = nbytes(sz);
    if (nb == 4) return rd;
    v    = rd >> (8 * int'(ao[1:0]));
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v    = v & mask;
    if (sx && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic drive_idle();
    m_valid = 0; m_flush = 0; m_ld = 0; m_st = 0; m_size = 0; m_sext = 0;
    m_ao = 0; m_rt = 0; fwd_sel = 0; fwd_data = 0; m_ir = 0; m_pc4 = 0;
    bus_ready = 0; bus_rdata = 0;
  endtask

  // Runs one M-stage instruction from a negedge until its W entry is visible.
  // waits = cycles before bus_ready; anything above TO never answers.
  task automatic run_instr(input string name, input logic vld, input logic ld,
                           input logic st, input logic [1:0] sz, input logic sx,
                           input logic [31:0] ao, input logic [31:0] rt,
                           input logic fs, input logic [31:0] fd,
                           input logic [31:0] rdata, input int waits);
    logic [31:0] ir, pc4, sd, e_dr;
    logic        memop, mis, use_bus, tout, e_exc;
    logic [4:0]  e_code;
    int          last;
    ir      = $urandom();
    pc4     = $urandom();
    sd      = fs ? fd : rt;
    memop   = vld && (ld || st);
    mis     = memop && ((int'(ao[1:0]) % nbytes(sz)) != 0);
    use_bus = memop && !mis;
    tout    = use_bus && (waits > TO);
    last    = !use_bus ? 0 : (tout ? TO : waits);
    for (int k = 0; k <= last; k++) begin
      m_valid = vld; m_flush = 0; m_ld = ld; m_st = st; m_size = sz; m_sext = sx;
      m_ao = ao; m_rt = rt; fwd_sel = fs; m_ir = ir; m_pc4 = pc4;
      fwd_data  = (k == 0) ? fd : $urandom();
      bus_ready = use_bus ? (k == waits) : 1'($urandom_range(0, 1));
      bus_rdata = (use_bus && k == waits) ? rdata : $urandom();
      #1;
      n_cmp++;
      if (bus_req !== use_bus) begin
        n_fail++; $display("FAIL %s bus_req c%0d: got %b exp %b", name, k, bus_req, use_bus);
      end
      n_cmp++;
      if (stall_o !== (use_bus && k < last)) begin
        n_fail++; $display("FAIL %s stall c%0d: got %b exp %b", name, k, stall_o, use_bus && k < last);
      end
      if (use_bus) begin
        n_cmp++;
        if (bus_addr !== (ao & 32'hFFFF_FFFC)) begin
          n_fail++; $display("FAIL %s bus_addr c%0d: got %h exp %h", name, k, bus_addr, ao & 32'hFFFF_FFFC);
        end
        n_cmp++;
        if (bus_be !== ref_be(sz, ao)) begin
          n_fail++; $display("FAIL %s bus_be c%0d: got %b exp %b", name, k, bus_be, ref_be(sz, ao));
        end
        n_cmp++;
        if (bus_we !== st) begin
          n_fail++; $display("FAIL %s bus_we c%0d: got %b exp %b", name, k, bus_we, st);
        end
        if (st) begin
          n_cmp++;
          if (bus_wdata !== ref_wdata(sz, sd)) begin
            n_fail++; $display("FAIL %s bus_wdata c%0d: got %h exp %h", name, k, bus_wdata, ref_wdata(sz, sd));
          end
        end
      end
      if (k > 0) begin
        n_cmp++;
        if (w_valid !== 1'b0 || w_ir !== 32'd0 || w_exc !== 1'b0) begin
          n_fail++; $display("FAIL %s bubble c%0d: got v=%b ir=%h exc=%b exp 0/0/0", name, k, w_valid, w_ir, w_exc);
        end
      end
      @(negedge clk);
    end
    e_exc  = mis || tout;
    e_code = tout ? 5'd7 : (mis ? (ld ? 5'd4 : 5'd5) : 5'd0);
    e_dr   = (ld && use_bus && !tout) ? ref_load(sz, sx, ao, rdata) : 32'd0;
    n_cmp++;
    if (w_valid !== vld || w_exc !== e_exc || w_exc_code !== e_code) begin
      n_fail++; $display("FAIL %s w_status: got v=%b exc=%b code=%0d exp v=%b exc=%b code=%0d",
                         name, w_valid, w_exc, w_exc_code, vld, e_exc, e_code);
    end
    n_cmp++;
    if (w_dr !== e_dr) begin
      n_fail++; $display("FAIL %s w_dr: got %h exp %h", name, w_dr, e_dr);
    end
    n_cmp++;
    if (w_ao !== ao || w_ir !== ir || w_pc4 !== pc4) begin
      n_fail++; $display("FAIL %s w_fields: got ao=%h ir=%h pc4=%h exp %h %h %h",
                         name, w_ao, w_ir, w_pc4, ao, ir, pc4);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (w_valid !== 0 || w_exc !== 0 || w_exc_code !== 0 || w_dr !== 0 ||
        w_ao !== 0 || w_ir !== 0 || w_pc4 !== 0) begin
      n_fail++; $display("FAIL reset_w: got v=%b exc=%b ao=%h ir=%h exp all zero", w_valid, w_exc, w_ao, w_ir);
    end
    n_cmp++;
    if (bus_req !== 0 || stall_o !== 0) begin
      n_fail++; $display("FAIL reset_bus: got req=%b stall=%b exp 0/0", bus_req, stall_o);
    end
    rst = 0;
  endtask

  task automatic test_directed();
    run_instr("sb_1003", 1, 0, 1, 2'd0, 0, 32'h1003, 32'h0000_00A5, 0, 0, $urandom(), 0);
    run_instr("lh_2002", 1, 1, 0, 2'd1, 1, 32'h2002, 0, 0, 0, 32'h8001_1234, 0);
    run_instr("lhu_2002", 1, 1, 0, 2'd1, 0, 32'h2002, 0, 0, 0, 32'h8001_1234, 0);
    run_instr("sw_fwd_w3", 1, 0, 1, 2'd2, 0, 32'h3000, 32'h1111_1111, 1, 32'hDEAD_BEEF, 0, 3);
    run_instr("lw_mis", 1, 1, 0, 2'd2, 0, 32'h0002, 0, 0, 0, $urandom(), 0);
    run_instr("sh_mis", 1, 0, 1, 2'd1, 0, 32'h0001, 32'h1234, 0, 0, $urandom(), 0);
    run_instr("lb_w4", 1, 1, 0, 2'd0, 1, 32'h0041, 0, 0, 0, 32'h0000_F000, 4);
    run_instr("nonmem", 1, 0, 0, 2'd2, 0, 32'h0000_0007, 0, 0, 0, $urandom(), 0);
  endtask

  task automatic test_timeout();
    run_instr("lw_timeout", 1, 1, 0, 2'd2, 0, 32'h0000_0100, 0, 0, 0, $urandom(), 99);
    run_instr("sw_timeout", 1, 0, 1, 2'd3, 0, 32'h0000_0204, 32'h5555_AAAA, 0, 0, 0, 99);
    run_instr("idle_after_to", 0, 0, 0, 2'd0, 0, 32'h0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flush_wait();
    // flush in WAIT, memory answers two cycles later
    drive_idle();
    m_valid = 1; m_st = 1; m_size = 2'd2; m_ao = 32'h40; m_rt = 32'hCAFE_0001; m_ir = 32'h1;
    for (int k = 0; k < 5; k++) begin
      m_flush   = (k == 1);
      if (k >= 2) m_valid = 0;
      bus_ready = (k == 3);
      #1;
      n_cmp++;
      if (bus_req !== (k < 4) || stall_o !== (k < 3)) begin
        n_fail++; $display("FAIL flush_drain c%0d: got req=%b stall=%b exp %b/%b", k, bus_req, stall_o, k < 4, k < 3);
      end
      @(negedge clk);
      n_cmp++;
      if (w_valid !== 0 || w_exc !== 0) begin
        n_fail++; $display("FAIL flush_drain_w c%0d: got v=%b exc=%b exp 0/0", k, w_valid, w_exc);
      end
    end
    // flush and ready together in WAIT
    drive_idle();
    m_valid = 1; m_ld = 1; m_size = 2'd2; m_ao = 32'h80; m_ir = 32'h2;
    #1;
    @(negedge clk);
    m_flush = 1; bus_ready = 1; bus_rdata = 32'h1234_5678;
    #1;
    n_cmp++;
    if (stall_o !== 0 || bus_req !== 1) begin
      n_fail++; $display("FAIL flush_ready: got stall=%b req=%b exp 0/1", stall_o, bus_req);
    end
    @(negedge clk);
    n_cmp++;
    if (w_valid !== 0 || w_ir !== 0 || w_exc !== 0) begin
      n_fail++; $display("FAIL flush_ready_w: got v=%b ir=%h exc=%b exp 0/0/0", w_valid, w_ir, w_exc);
    end
    run_instr("after_flush", 1, 1, 0, 2'd0, 0, 32'h0000_0093, 0, 0, 0, 32'h8000_0000, 0);
  endtask

  task automatic test_reset_mid_wait();
    run_instr("pre_reset", 1, 0, 0, 2'd0, 0, $urandom() | 32'h1, 0, 0, 0, 0, 0);
    drive_idle();
    m_valid = 1; m_ld = 1; m_size = 2'd2; m_ao = 32'h0000_0300;
    @(negedge clk);
    #2;
    rst = 1; m_valid = 0;
    #1;
    n_cmp++;
    if (bus_req !== 0 || stall_o !== 0) begin
      n_fail++; $display("FAIL reset_wait_bus: got req=%b stall=%b exp 0/0", bus_req, stall_o);
    end
    n_cmp++;
    if (w_ao !== 0 || w_pc4 !== 0 || w_ir !== 0 || w_valid !== 0) begin
      n_fail++; $display("FAIL reset_wait_w: got ao=%h pc4=%h ir=%h v=%b exp zero", w_ao, w_pc4, w_ir, w_valid);
    end
    @(negedge clk);
    rst = 0;
    run_instr("post_reset", 1, 1, 0, 2'd1, 1, 32'h0000_0302, 0, 0, 0, 32'hFFFE_0000, 0);
  endtask

  task automatic test_random(input int n, input int max_wait);
    logic [1:0]  sz;
    logic [31:0] ao;
    int          op, w;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      ao = $urandom();
      if ($urandom_range(0, 3) != 0) ao = ao & ~32'(nbytes(sz) - 1);
      w  = $urandom_range(0, max_wait);
      if (max_wait > 0 && $urandom_range(0, 9) == 0) w = 9;
      run_instr("rand", 1'($urandom_range(0, 7) != 0), op == 1, op == 2, sz,
                1'($urandom_range(0, 1)), ao, $urandom(), 1'($urandom_range(0, 1)),
                $urandom(), $urandom(), w);
    end
  endtask

  initial begin
    rst = 1;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_directed();
    test_timeout();
    test_flush_wait();
    test_reset_mid_wait();
    test_random(12, 0);   // back-to-back zero-wait accesses
    test_random(60, 4);
    drive_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, exp finish before 500000");
    $fatal(1, "watchdog");
  end

endmodule
